// File: rtl/frv_rng_responder_if.sv
// Request/response handshake bundle between the core's RNG initiator
// and the PRNG responder.
interface frv_rng_responder_if;
  logic        rng_req_valid;
  logic [2:0]  rng_req_op;
  logic [31:0] rng_req_data;
  logic        rng_req_ready;
  logic        rng_rsp_valid;
  logic [2:0]  rng_rsp_status;
  logic [31:0] rng_rsp_data;
  logic        rng_rsp_ready;

  modport master (
    output rng_req_valid,
    output rng_req_op,
    output rng_req_data,
    output rng_rsp_ready,
    input  rng_req_ready,
    input  rng_rsp_valid,
    input  rng_rsp_status,
    input  rng_rsp_data
  );

  modport slave (
    input  rng_req_valid,
    input  rng_req_op,
    input  rng_req_data,
    input  rng_rsp_ready,
    output rng_req_ready,
    output rng_rsp_valid,
    output rng_rsp_status,
    output rng_rsp_data
  );
endinterface

// File: rtl/frv_rng_responder.sv
// xorshift32 PRNG responder: one registered response per request,
// optional extra latency to mimic a slow entropy source.
module frv_rng_responder #(
  parameter int RSP_LATENCY = 0,
  parameter int SEED_MIN    = 1
) (
  input  logic g_clk,
  input  logic g_reset,
  frv_rng_responder_if.slave rng
);

  localparam int CW = (RSP_LATENCY > 0) ?
                      $clog2(RSP_LATENCY + 1) : 1;
  localparam int SW = $clog2(SEED_MIN + 1);

  localparam logic [2:0] ST_NO_INIT   = 3'b000;
  localparam logic [2:0] ST_UNHEALTHY = 3'b001;
  localparam logic [2:0] ST_HEALTHY   = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [31:0]    r_prng;
  logic [SW-1:0]  r_seed_cnt;
  logic           r_unh;
  logic [2:0]     r_status;
  logic [31:0]    r_data;

  logic           w_accept;
  logic           w_seed;
  logic           w_samp;
  logic           w_dnz;
  logic           w_healthy;
  logic [31:0]    w_xor;
  logic [31:0]    w_xs;
  logic [31:0]    w_prng_nxt;
  logic [SW-1:0]  w_cnt_nxt;
  logic           w_unh_nxt;
  logic [31:0]    w_data_nxt;
  logic [2:0]     w_status_nxt;

  function automatic logic [31:0] xs32(
    input logic [31:0] x
  );
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [2:0] status_of(
    input logic          unh,
    input logic [SW-1:0] cnt
  );
    if (unh)
      return ST_UNHEALTHY;
    if (cnt >= SW'(SEED_MIN))
      return ST_HEALTHY;
    return ST_NO_INIT;
  endfunction

  assign rng.rng_req_ready  = (r_state == S_IDLE)
                              & ~g_reset;
  assign rng.rng_rsp_valid  = (r_state == S_RESP);
  assign rng.rng_rsp_status = r_status;
  assign rng.rng_rsp_data   = r_data;

  assign w_accept  = rng.rng_req_valid
                     & rng.rng_req_ready;
  assign w_seed    = (rng.rng_req_op == 3'b001);
  assign w_samp    = (rng.rng_req_op == 3'b010);
  assign w_dnz     = (rng.rng_req_data != 32'h0);
  assign w_xor     = r_prng ^ rng.rng_req_data;
  assign w_xs      = xs32(r_prng);
  assign w_healthy = (status_of(r_unh, r_seed_cnt)
                      == ST_HEALTHY);

  // Effects of the presented op; committed only on accept.
  always_comb begin
    w_prng_nxt = r_prng;
    w_cnt_nxt  = r_seed_cnt;
    w_unh_nxt  = r_unh;
    w_data_nxt = 32'h0;
    unique case (1'b1)
      w_seed && w_dnz: begin
        w_prng_nxt = (w_xor == 32'h0) ?
                     32'h1 : w_xor;
        w_cnt_nxt  = (r_seed_cnt == SW'(SEED_MIN)) ?
                     r_seed_cnt :
                     r_seed_cnt + SW'(1);
        w_unh_nxt  = 1'b0;
      end
      w_seed && !w_dnz: begin
        w_unh_nxt = 1'b1;
        w_cnt_nxt = '0;
      end
      w_samp && w_healthy: begin
        w_prng_nxt = w_xs;
        w_data_nxt = w_xs;
      end
      default: ;
    endcase
    w_status_nxt = status_of(w_unh_nxt, w_cnt_nxt);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept)
          w_state_nxt = (RSP_LATENCY > 0) ?
                        S_BUSY : S_RESP;
      S_BUSY:
        if (r_cnt <= CW'(1))
          w_state_nxt = S_RESP;
      S_RESP:
        if (rng.rng_rsp_ready)
          w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)
      r_cnt <= '0;
    else if (w_accept)
      r_cnt <= CW'(RSP_LATENCY);
    else if (r_state == S_BUSY)
      r_cnt <= r_cnt - CW'(1);
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_prng     <= 32'h0;
      r_seed_cnt <= '0;
      r_unh      <= 1'b0;
      r_status   <= ST_NO_INIT;
      r_data     <= 32'h0;
    end else if (w_accept) begin
      r_prng     <= w_prng_nxt;
      r_seed_cnt <= w_cnt_nxt;
      r_unh      <= w_unh_nxt;
      r_status   <= w_status_nxt;
      r_data     <= w_data_nxt;
    end
  end

endmodule

// File: tb/tb_frv_rng_responder.sv
// Bench for frv_rng_responder: latency-0 and latency-3 instances,
// directed vectors plus a spec-level model checked every cycle.
module tb_frv_rng_responder;

  localparam logic [2:0] OP_SEED = 3'b001;
  localparam logic [2:0] OP_SAMP = 3'b010;
  localparam logic [2:0] OP_TEST = 3'b100;

  logic g_clk = 1'b0;
  logic g_reset = 1'b1;
  always #5 g_clk = ~g_clk;

  frv_rng_responder_if b0();
  frv_rng_responder_if b1();

  frv_rng_responder #(
    .RSP_LATENCY(0), .SEED_MIN(1)
  ) u_l0 (
    .g_clk(g_clk), .g_reset(g_reset), .rng(b0)
  );

  frv_rng_responder #(
    .RSP_LATENCY(3), .SEED_MIN(2)
  ) u_l3 (
    .g_clk(g_clk), .g_reset(g_reset), .rng(b1)
  );

  logic        v[2];
  logic [2:0]  op[2];
  logic [31:0] dat[2];
  logic        rr[2];
  logic        rdy_o[2];
  logic        vld_o[2];
  logic [2:0]  st_o[2];
  logic [31:0] dat_o[2];

  assign b0.rng_req_valid = v[0];
  assign b0.rng_req_op    = op[0];
  assign b0.rng_req_data  = dat[0];
  assign b0.rng_rsp_ready = rr[0];
  assign b1.rng_req_valid = v[1];
  assign b1.rng_req_op    = op[1];
  assign b1.rng_req_data  = dat[1];
  assign b1.rng_rsp_ready = rr[1];
  assign rdy_o[0] = b0.rng_req_ready;
  assign vld_o[0] = b0.rng_rsp_valid;
  assign st_o[0]  = b0.rng_rsp_status;
  assign dat_o[0] = b0.rng_rsp_data;
  assign rdy_o[1] = b1.rng_req_ready;
  assign vld_o[1] = b1.rng_rsp_valid;
  assign st_o[1]  = b1.rng_rsp_status;
  assign dat_o[1] = b1.rng_rsp_data;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h want %h",
               name, act, exp);
  endtask

  // Spec-level model state per instance.
  logic [31:0] m_prng[2];
  int          m_seeds[2];
  bit          m_unh[2];
  logic [34:0] q0[$];
  logic [34:0] q1[$];

  function automatic logic [31:0] m_xs(
    input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic int smin(input int w);
    return (w == 0) ? 1 : 2;
  endfunction

  function automatic int lat_of(input int w);
    return (w == 0) ? 0 : 3;
  endfunction

  function automatic logic [2:0] m_status(
    input int w);
    if (m_unh[w]) return 3'b001;
    if (m_seeds[w] >= smin(w)) return 3'b010;
    return 3'b000;
  endfunction

  task automatic m_clear();
    for (int w = 0; w < 2; w++) begin
      m_prng[w]  = 32'h0;
      m_seeds[w] = 0;
      m_unh[w]   = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic m_accept(input int w,
                          input logic [2:0] o,
                          input logic [31:0] d);
    logic [31:0] rd;
    rd = 32'h0;
    if (o == OP_SEED) begin
      if (d != 0) begin
        m_prng[w] = ((m_prng[w] ^ d) == 0) ?
                    32'h1 : (m_prng[w] ^ d);
        m_seeds[w]++;
        m_unh[w] = 1'b0;
      end else begin
        m_unh[w] = 1'b1;
        m_seeds[w] = 0;
      end
    end else if (o == OP_SAMP &&
                 m_status(w) == 3'b010) begin
      m_prng[w] = m_xs(m_prng[w]);
      rd = m_prng[w];
    end
    if (w == 0) q0.push_back({m_status(w), rd});
    else        q1.push_back({m_status(w), rd});
  endtask

  // Per-cycle compare of every visible response.
  always @(negedge g_clk) begin
    if (!g_reset) begin
      for (int w = 0; w < 2; w++) begin
        logic [34:0] e;
        int sz;
        if (v[w] && rdy_o[w])
          m_accept(w, op[w], dat[w]);
        if (vld_o[w]) begin
          sz = (w == 0) ? q0.size() : q1.size();
          if (sz == 0) begin
            n_chk++;
            $display("FAIL rsp_unexpected[%0d]: got valid want idle", w);
          end else begin
            e = (w == 0) ? q0[0] : q1[0];
            check($sformatf("model_status[%0d]", w),
                  32'(st_o[w]), 32'(e[34:32]));
            check($sformatf("model_data[%0d]", w),
                  dat_o[w], e[31:0]);
            if (rr[w]) begin
              if (w == 0) void'(q0.pop_front());
              else        void'(q1.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic xact(input int w,
                      input logic [2:0] o,
                      input logic [31:0] d,
                      input int stall,
                      input bit chk,
                      input logic [2:0] es,
                      input logic [31:0] ed);
    int n;
    v[w] = 1'b1;
    op[w] = o;
    dat[w] = d;
    n = 0;
    while (!rdy_o[w] && n < 50) begin
      @(posedge g_clk); #1;
      n++;
    end
    if (n >= 50) check("accept_timeout", 1, 0);
    @(posedge g_clk); #1;
    v[w] = 1'b0;
    op[w] = 3'($urandom);
    dat[w] = $urandom;
    n = 0;
    while (!vld_o[w] && n < 50) begin
      check("ready_low_busy", 32'(rdy_o[w]), 0);
      @(posedge g_clk); #1;
      n++;
    end
    check("latency", n, lat_of(w));
    check("ready_low_resp", 32'(rdy_o[w]), 0);
    if (chk) begin
      check("lit_status", 32'(st_o[w]), 32'(es));
      check("lit_data", dat_o[w], ed);
    end
    repeat (stall) begin
      @(posedge g_clk); #1;
      check("hold_valid", 32'(vld_o[w]), 1);
    end
    rr[w] = 1'b1;
    @(posedge g_clk); #1;
    rr[w] = 1'b0;
    check("ready_after_hs", 32'(rdy_o[w]), 1);
    check("valid_after_hs", 32'(vld_o[w]), 0);
  endtask

  task automatic do_reset();
    g_reset = 1'b1;
    m_clear();
    #1;
    for (int w = 0; w < 2; w++) begin
      check("rst_ready", 32'(rdy_o[w]), 0);
      check("rst_valid", 32'(vld_o[w]), 0);
      check("rst_status", 32'(st_o[w]), 0);
      check("rst_data", dat_o[w], 0);
    end
    repeat (2) @(posedge g_clk);
    #1;
    g_reset = 1'b0;
    #1;
    check("rel_ready0", 32'(rdy_o[0]), 1);
    check("rel_ready1", 32'(rdy_o[1]), 1);
    @(posedge g_clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 2; w++) begin
      v[w] = 1'b0;
      op[w] = 3'b0;
      dat[w] = 32'h0;
      rr[w] = 1'b0;
    end
    do_reset();

    xact(0, OP_TEST, 32'h0, 0, 1, 3'b000, 32'h0);
    xact(0, OP_SEED, 32'h1, 0, 1, 3'b010, 32'h0);
    xact(0, OP_SAMP, 32'h0, 0, 1, 3'b010, 32'h00042021);
    xact(0, OP_SAMP, 32'h0, 1, 1, 3'b010, 32'h04080601);

    do_reset();
    xact(0, OP_SAMP, 32'h0, 0, 1, 3'b000, 32'h0);
    xact(0, OP_SEED, 32'h1, 0, 1, 3'b010, 32'h0);
    xact(0, OP_SAMP, 32'h0, 0, 1, 3'b010, 32'h00042021);

    xact(0, OP_SEED, 32'h0, 0, 1, 3'b001, 32'h0);
    xact(0, OP_SAMP, 32'h0, 0, 1, 3'b001, 32'h0);
    xact(0, OP_SEED, 32'h5, 0, 1, 3'b010, 32'h0);
    xact(0, OP_SAMP, 32'h0, 0, 0, 3'b000, 32'h0);
    xact(0, 3'b011, 32'hdead, 0, 1, 3'b010, 32'h0);

    do_reset();
    xact(0, OP_SEED, 32'h1, 0, 1, 3'b010, 32'h0);
    xact(0, OP_SEED, 32'h1, 0, 1, 3'b010, 32'h0);
    xact(0, OP_SAMP, 32'h0, 0, 1, 3'b010, 32'h00042021);

    xact(1, OP_SEED, 32'h7, 0, 1, 3'b000, 32'h0);
    xact(1, OP_SEED, 32'h7, 0, 1, 3'b010, 32'h0);
    xact(1, OP_SAMP, 32'h0, 4, 1, 3'b010, 32'h00042021);
    for (int i = 0; i < 6; i++)
      xact(1, OP_SAMP, 32'h0, $urandom_range(0, 3),
           0, 3'b000, 32'h0);
    xact(1, OP_TEST, 32'h0, 2, 1, 3'b010, 32'h0);

    v[0] = 1'b1;
    op[0] = OP_TEST;
    dat[0] = 32'h0;
    @(posedge g_clk); #1;
    v[0] = 1'b0;
    check("pre_rst_valid", 32'(vld_o[0]), 1);
    #2;
    g_reset = 1'b1;
    #1;
    check("async_drop_valid", 32'(vld_o[0]), 0);
    do_reset();
    xact(0, OP_TEST, 32'h0, 0, 1, 3'b000, 32'h0);

    repeat (2) @(posedge g_clk);
    #1;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
